// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
// Imported by the interface, the top and its testbench.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_WIN_W = 16;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle between a frequency meter and its user.
// The master requests windows, the slave (the meter) reports results.
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             cont;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output start, cont,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, cont,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop giving a rising-edge pulse.
// Suitable for any slow asynchronous input such as a divided clock.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;
endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES sys_clk window.
// Single-shot on start, back-to-back windows while cont is high.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         sig_in,
    freq_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);

    state_t           state;
    logic [WIN_W-1:0] win;
    logic [CNT_W-1:0] acc;
    logic             sat;
    logic             pulse;
    logic             at_max;
    logic             last;

    sync_edge_det u_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .pulse (pulse)
    );

    assign at_max = (acc == CNT_MAX);
    assign last = (win == '0);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            win <= '0;
            acc <= '0;
            sat <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.count <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start || bus.cont) begin
                        state <= ST_GATE;
                        bus.busy <= 1'b1;
                        win <= WIN_LOAD;
                        acc <= '0;
                        sat <= 1'b0;
                    end
                end
                ST_GATE: begin
                    if (last) begin
                        // final cycle's edge is folded into the result
                        bus.count <= (pulse && !at_max) ? acc + 1'b1 : acc;
                        bus.overflow <= sat | (pulse & at_max);
                        bus.done <= 1'b1;
                        win <= WIN_LOAD;
                        acc <= '0;
                        sat <= 1'b0;
                        if (!bus.cont) begin
                            state <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        win <= win - 1'b1;
                        if (pulse) begin
                            if (at_max) sat <= 1'b1;
                            else acc <= acc + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit and an 8-bit instance
// share clock, reset and sig_in; each task checks one scenario.
module tb_freq_meter;
    import freq_meter_pkg::*;

    logic sys_clk = 1'b0;
    logic rst_n;
    logic sig_in = 1'b0;
    logic sel;
    int   per;
    int   lvl;
    int   ph = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    freq_meter_if #(.CNT_W(16)) f16 ();
    freq_meter_if #(.CNT_W(8))  f8 ();

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(16), .WIN_W(16)) u16 (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .bus     (f16.slave)
    );

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(8), .WIN_W(16)) u8 (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .bus     (f8.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // sig_in generator: period per sys_clk cycles, or constant lvl when per==0
    always begin
        @(posedge sys_clk);
        #2;
        if (per == 0) begin
            sig_in = lvl[0];
        end else begin
            ph++;
            if (ph >= per / 2) begin
                ph = 0;
                sig_in = ~sig_in;
            end
        end
    end

    logic        m_busy;
    logic        m_done;
    logic [15:0] m_count;
    logic        m_ovf;
    assign m_busy = sel ? f8.busy : f16.busy;
    assign m_done = sel ? f8.done : f16.done;
    assign m_count = sel ? {8'd0, f8.count} : f16.count;
    assign m_ovf = sel ? f8.overflow : f16.overflow;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) f8.start = v;
        else f16.start = v;
    endtask

    task automatic set_cont(input logic v);
        if (sel) f8.cont = v;
        else f16.cont = v;
    endtask

    task automatic pulse_start;
        set_start(1'b1);
        tick;
        set_start(1'b0);
    endtask

    // observe n cycles from cycle 1 after the sampling edge
    task automatic run_mon(input int n, input int restart_at,
                           output int bc, output int dc, output int da);
        bc = 0;
        dc = 0;
        da = 0;
        for (int i = 1; i <= n; i++) begin
            if (i == restart_at) set_start(1'b1);
            if (i == restart_at + 1) set_start(1'b0);
            if (m_busy) bc++;
            if (m_done) begin
                dc++;
                if (da == 0) da = i;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        int bc, dc, da;
        sel = 1'b0;
        rst_n = 1'b0;
        per = 2;
        repeat (3) tick;
        n_chk++;
        if (f16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got %b want 0", f16.busy);
        end
        n_chk++;
        if (f16.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_done: got %b want 0", f16.done);
        end
        n_chk++;
        if (f16.count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_count: got %0d want 0", f16.count);
        end
        n_chk++;
        if (f16.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ovf: got %b want 0", f16.overflow);
        end
        n_chk++;
        if ({f8.busy, f8.done, f8.overflow, f8.count} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_f8: got b%b d%b o%b c%0d want all 0",
                     f8.busy, f8.done, f8.overflow, f8.count);
        end
        rst_n = 1'b1;
        run_mon(20, 0, bc, dc, da);
        n_chk++;
        if (bc !== 0 || dc !== 0) begin
            n_fail++;
            $display("FAIL idle_after_rst: got busy %0d done %0d want 0 0",
                     bc, dc);
        end
    endtask

    task automatic test_div2;
        int bc, dc, da;
        sel = 1'b0;
        per = 2;
        repeat (10) tick;
        pulse_start;
        run_mon(1005, 0, bc, dc, da);
        n_chk++;
        if (bc !== 1000) begin
            n_fail++;
            $display("FAIL div2_busy: got %0d cycles want 1000", bc);
        end
        n_chk++;
        if (dc !== 1 || da !== 1001) begin
            n_fail++;
            $display("FAIL div2_done: got %0d at %0d want 1 at 1001", dc, da);
        end
        n_chk++;
        if (m_count !== 16'd500) begin
            n_fail++;
            $display("FAIL div2_count: got %0d want 500", m_count);
        end
        n_chk++;
        if (m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL div2_ovf: got %b want 0", m_ovf);
        end
        repeat (10) tick;
        n_chk++;
        if (m_count !== 16'd500) begin
            n_fail++;
            $display("FAIL div2_hold: got %0d want 500", m_count);
        end
    endtask

    task automatic test_restart_ignored;
        int bc, dc, da;
        sel = 1'b0;
        per = 10;
        repeat (20) tick;
        pulse_start;
        run_mon(1010, 200, bc, dc, da);
        n_chk++;
        if (dc !== 1 || da !== 1001) begin
            n_fail++;
            $display("FAIL p10_done: got %0d at %0d want 1 at 1001", dc, da);
        end
        n_chk++;
        if (bc !== 1000) begin
            n_fail++;
            $display("FAIL p10_busy: got %0d cycles want 1000", bc);
        end
        n_chk++;
        if (m_count !== 16'd100) begin
            n_fail++;
            $display("FAIL p10_count: got %0d want 100", m_count);
        end
    endtask

    task automatic test_overflow;
        int bc, dc, da;
        sel = 1'b1;
        per = 2;
        repeat (10) tick;
        pulse_start;
        run_mon(1005, 0, bc, dc, da);
        n_chk++;
        if (dc !== 1 || da !== 1001) begin
            n_fail++;
            $display("FAIL ovf_done: got %0d at %0d want 1 at 1001", dc, da);
        end
        n_chk++;
        if (m_count !== 16'd255) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d want 255", m_count);
        end
        n_chk++;
        if (m_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b want 1", m_ovf);
        end
        per = 20;
        repeat (30) tick;
        pulse_start;
        run_mon(1005, 0, bc, dc, da);
        n_chk++;
        if (dc !== 1 || da !== 1001) begin
            n_fail++;
            $display("FAIL p20_done: got %0d at %0d want 1 at 1001", dc, da);
        end
        n_chk++;
        if (m_count !== 16'd50) begin
            n_fail++;
            $display("FAIL p20_count: got %0d want 50", m_count);
        end
        n_chk++;
        if (m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL p20_ovf: got %b want 0", m_ovf);
        end
    endtask

    task automatic test_continuous;
        int bc;
        int dc;
        int at [4];
        sel = 1'b0;
        per = 4;
        bc = 0;
        dc = 0;
        at = '{0, 0, 0, 0};
        repeat (10) tick;
        set_cont(1'b1);
        tick;
        for (int i = 1; i <= 4010; i++) begin
            if (i == 3500) set_cont(1'b0);
            if (m_busy) bc++;
            if (m_done) begin
                if (dc < 4) at[dc] = i;
                dc++;
                n_chk++;
                if (m_count !== 16'd250) begin
                    n_fail++;
                    $display("FAIL cont_count: got %0d want 250 at %0d",
                             m_count, i);
                end
            end
            tick;
        end
        n_chk++;
        if (dc !== 4) begin
            n_fail++;
            $display("FAIL cont_ndone: got %0d want 4", dc);
        end
        n_chk++;
        if (at[0] !== 1001 || at[1] !== 2001 || at[2] !== 3001 || at[3] !== 4001) begin
            n_fail++;
            $display("FAIL cont_times: got %0d %0d %0d %0d want 1001 2001 3001 4001",
                     at[0], at[1], at[2], at[3]);
        end
        n_chk++;
        if (bc !== 4000) begin
            n_fail++;
            $display("FAIL cont_busy: got %0d cycles want 4000", bc);
        end
    endtask

    task automatic test_reset_mid;
        int bc, dc, da;
        sel = 1'b0;
        per = 2;
        repeat (10) tick;
        pulse_start;
        repeat (499) tick;
        n_chk++;
        if (m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_pre: got %b want 1", m_busy);
        end
        rst_n = 1'b0;
        tick;
        n_chk++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_ctl: got busy %b done %b want 0 0",
                     m_busy, m_done);
        end
        n_chk++;
        if (m_count !== 16'd0 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_res: got count %0d ovf %b want 0 0",
                     m_count, m_ovf);
        end
        per = 0;
        lvl = 1;
        repeat (2) tick;
        rst_n = 1'b1;
        run_mon(1100, 0, bc, dc, da);
        n_chk++;
        if (dc !== 0 || bc !== 0) begin
            n_fail++;
            $display("FAIL mid_no_done: got done %0d busy %0d want 0 0", dc, bc);
        end
        pulse_start;
        run_mon(1005, 0, bc, dc, da);
        n_chk++;
        if (dc !== 1 || da !== 1001) begin
            n_fail++;
            $display("FAIL const_done: got %0d at %0d want 1 at 1001", dc, da);
        end
        n_chk++;
        if (m_count !== 16'd0 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL const_count: got %0d ovf %b want 0 0", m_count, m_ovf);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b0;
        per = 2;
        lvl = 0;
        f16.start = 1'b0;
        f16.cont = 1'b0;
        f8.start = 1'b0;
        f8.cont = 1'b0;
        test_reset;
        test_div2;
        test_restart_ignored;
        test_overflow;
        test_continuous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an asynchronous input signal, such as a divided clock, against sys_clk.
- Counts rising edges of sig_in over a gate window of GATE_CYCLES sys_clk cycles, then publishes the count.
- Single-shot or continuous operation.
- Sits alongside the clock-divider utilities. Used to verify divided clocks on hardware and to measure external periodic signals.

Parameters:
- GATE_CYCLES, 1000: gate window length in sys_clk cycles. Must be ≥2.
- CNT_W, 16: width of the edge counter and result.
- WIN_W, 16: width of the window down-counter. Must satisfy 2^WIN_W > GATE_CYCLES-1.

Ports:
- sys_clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  single-cycle request to begin one gate window.
- cont  input  1  continuous mode: windows repeat back-to-back while high.
- busy  output  1  high while a gate window is open.
- done  output  1  one-cycle pulse when count/overflow update.
- count  output  CNT_W  rising edges in the last completed window.
- overflow  output  1  last window saturated the counter.

Behaviour:
- Reset: rst_n is sampled on posedge sys_clk. When it is low, all of the following are cleared to 0: state, sync flops, edge history, window counter, accumulator, busy, done, count, overflow. Reset mid-window aborts the window with no done pulse.
- Synchroniser: sig_in passes through 2 flops (s1, s2), then a history flop s3. The edge pulse is s2 & ~s3, giving 3 cycles of input-to-pulse latency. Maximum measurable rate is sys_clk/2 (one rising edge every 2 cycles).
- FSM states:
  - IDLE: busy=0. If start or cont is sampled high, go to GATE next cycle. Load win=GATE_CYCLES-1, clear acc and the sat flag.
  - GATE: busy=1. Each cycle, if edge=1, acc increments. At 2^CNT_W-1, acc holds and the sat flag is set. win decrements each cycle. The cycle where win==0 is the last GATE cycle, and it is counted.
    - Last GATE cycle: register count ← acc + edge (saturating) and overflow ← sat, and pulse done=1 in the next cycle.
    - Next state is GATE if cont is sampled high in the last cycle (win reloaded, acc cleared, no gap cycle). Otherwise IDLE.
- Timing: start sampled in cycle t gives GATE cycles t+1..t+GATE_CYCLES. done and the new count are valid in cycle t+GATE_CYCLES+1. If that next state is IDLE, busy=0 in the same cycle.
- start while busy is ignored. start together with cont behaves like cont alone.
- An edge pulse in IDLE is discarded, including a spurious edge when sig_in is high at reset release.
- Dropping cont mid-window: the current window completes, then the block goes to IDLE.
- count and overflow hold their values between done pulses.

Decomposition:
- Package freq_meter_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GATE=1'b1.
  - default GATE_CYCLES/CNT_W localparams.
  - saturation max constant helper.
- Sub-module sync_edge_det: 2-flop synchroniser plus rising-edge pulse, with synchronous active-low reset. Reusable by other blocks that consume divided clocks.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with sig_in toggling → busy=0, done=0, count=0, overflow=0. Then release with no start → stays idle, no done.
- Divide-by-2 input: sig_in toggles every sys_clk cycle (period 2), GATE_CYCLES=1000, start pulse at cycle t → busy for cycles t+1..t+1000, done only at t+1001, count=500, overflow=0.
- Period 10 input with start re-pulsed at t+200 (while busy) → exactly one done at t+1001, count=100. The second start is ignored.
- Overflow: CNT_W=8, GATE_CYCLES=1000, period-2 input → count=255, overflow=1. Then a period-20 input window → count=50, overflow=0.
- Continuous: cont=1, period-4 input → done every 1000 cycles with no gap, count=250 each time. Deassert cont mid-window → exactly one more done, then busy=0.
- Reset mid-window: assert rst_n=0 at cycle t+500 → next cycle busy=0, count=0, no done. A following window with constant sig_in=1 → count=0.
